voice_scheduler: RTL and testbench

Polyphonic voice scheduler that time-multiplexes one phase-accumulator datapath across `NUM_VOICES` voices. It accepts note-on/note-off events through a valid/ready handshake and allocates them to voices: retrigger, lowest free voice, or steal the oldest. On every sample tick it sweeps all voices in index order, emitting each voice's wavetable address and interpolation fraction. It sits between the note/MIDI decode logic and the wavetable/interpolator/mixer chain.

---
 rtl/synth_pkg.sv | 33 +++
 rtl/voice_alloc.sv | 65 ++++++
 rtl/voice_scheduler.sv | 179 +++++++++++++++++
 tb/tb_voice_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the polyphonic voice scheduler.
package synth_pkg;

  localparam int unsigned PHASE_W = 32;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned FRAC_W  = 20;
  localparam int unsigned NOTE_W  = 7;
  // Wide enough for the largest supported voice count (16).
  localparam int unsigned RANK_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StEvent,
    StSweep
  } sched_state_e;

  typedef struct packed {
    logic               active;
    logic [NOTE_W-1:0]  note;
    logic [PHASE_W-1:0] inc;
    logic [PHASE_W-1:0] phase;
    logic [RANK_W-1:0]  rank;
  } voice_t;

  // Reset value of one voice: silent, zeroed, and aged by its index.
  function automatic voice_t voice_reset(int unsigned idx);
    voice_t v;
    v      = '0;
    v.rank = RANK_W'(idx);
    return v;
  endfunction

endpackage

// File: rtl/voice_alloc.sv
// Combinational voice allocator: picks the retrigger, free or steal target for an event.
module voice_alloc
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned VOICE_W    = $clog2(NUM_VOICES)
) (
  input  voice_t [NUM_VOICES-1:0] voices_i,
  input  logic                    note_on_i,
  input  logic [NOTE_W-1:0]       note_i,
  output logic [VOICE_W-1:0]      idx_o,
  output logic                    hit_o
);

  logic               match_found;
  logic               free_found;
  logic [VOICE_W-1:0] match_idx;
  logic [VOICE_W-1:0] free_idx;
  logic [VOICE_W-1:0] steal_idx;
  logic               unused_fields;

  // Scan downwards so the lowest matching / free index wins.
  always_comb begin
    match_found = 1'b0;
    free_found  = 1'b0;
    match_idx   = '0;
    free_idx    = '0;
    steal_idx   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (voices_i[i].active && (voices_i[i].note == note_i)) begin
        match_found = 1'b1;
        match_idx   = VOICE_W'(i);
      end
      if (!voices_i[i].active) begin
        free_found = 1'b1;
        free_idx   = VOICE_W'(i);
      end
      if (voices_i[i].rank == RANK_W'(NUM_VOICES - 1)) begin
        steal_idx = VOICE_W'(i);
      end
    end
  end

  always_comb begin
    if (match_found) begin
      idx_o = match_idx;
    end else if (note_on_i && free_found) begin
      idx_o = free_idx;
    end else if (note_on_i) begin
      idx_o = steal_idx;
    end else begin
      idx_o = match_idx;
    end
    // A note-on always lands somewhere; a note-off only acts on a match.
    hit_o = match_found | note_on_i;
  end

  always_comb begin
    unused_fields = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      unused_fields = unused_fields ^ (^{voices_i[i].inc, voices_i[i].phase});
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexed phase-accumulator scheduler: allocates note events to voices and
// sweeps all voices once per sample tick.
module voice_scheduler
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned VOICE_W    = $clog2(NUM_VOICES)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               sampleTick,
  input  logic               evtValid,
  output logic               evtReady,
  input  logic               evtNoteOn,
  input  logic [6:0]         evtNote,
  input  logic [31:0]        evtPhaseInc,
  output logic               outValid,
  output logic [VOICE_W-1:0] outVoice,
  output logic               outGate,
  output logic [11:0]        wavetableAddr,
  output logic [19:0]        interp,
  output logic               frameDone,
  output logic               overrun
);

  sched_state_e              state_q, state_d;
  voice_t [NUM_VOICES-1:0]   voices_q, voices_d;
  logic [VOICE_W-1:0]        cnt_q, cnt_d;
  logic                      pending_q, pending_d;
  logic                      overrun_q, overrun_d;
  logic                      evt_on_q, evt_on_d;
  logic [NOTE_W-1:0]         evt_note_q, evt_note_d;
  logic [PHASE_W-1:0]        evt_inc_q, evt_inc_d;
  logic                      out_valid_q, out_valid_d;
  logic [VOICE_W-1:0]        out_voice_q, out_voice_d;
  logic                      out_gate_q, out_gate_d;
  logic [ADDR_W-1:0]         out_addr_q, out_addr_d;
  logic [FRAC_W-1:0]         out_interp_q, out_interp_d;
  logic                      frame_done_q, frame_done_d;

  logic [VOICE_W-1:0]        alloc_idx;
  logic                      alloc_hit;
  logic [RANK_W-1:0]         old_rank;

  voice_alloc #(
    .NUM_VOICES (NUM_VOICES),
    .VOICE_W    (VOICE_W)
  ) u_voice_alloc (
    .voices_i  (voices_q),
    .note_on_i (evt_on_q),
    .note_i    (evt_note_q),
    .idx_o     (alloc_idx),
    .hit_o     (alloc_hit)
  );

  assign evtReady = (state_q == StIdle) && !pending_q && !sampleTick;

  always_comb begin
    state_d      = state_q;
    voices_d     = voices_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    evt_on_d     = evt_on_q;
    evt_note_d   = evt_note_q;
    evt_inc_d    = evt_inc_q;
    out_valid_d  = 1'b0;
    out_voice_d  = out_voice_q;
    out_gate_d   = 1'b0;
    out_addr_d   = out_addr_q;
    out_interp_d = out_interp_q;
    frame_done_d = 1'b0;
    old_rank     = voices_q[alloc_idx].rank;

    unique case (state_q)
      StIdle: begin
        if (pending_q || sampleTick) begin
          // A fresh tick on top of an unserved one is a lost tick.
          if (pending_q && sampleTick) overrun_d = 1'b1;
          pending_d = 1'b0;
          cnt_d     = '0;
          state_d   = StSweep;
        end else if (evtValid && evtReady) begin
          evt_on_d   = evtNoteOn;
          evt_note_d = evtNote;
          evt_inc_d  = evtPhaseInc;
          state_d    = StEvent;
        end
      end

      StEvent: begin
        if (alloc_hit) begin
          if (evt_on_q) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
              if (voices_q[v].rank < old_rank) voices_d[v].rank = voices_q[v].rank + 1'b1;
            end
            voices_d[alloc_idx].active = 1'b1;
            voices_d[alloc_idx].note   = evt_note_q;
            voices_d[alloc_idx].inc    = evt_inc_q;
            voices_d[alloc_idx].phase  = '0;
            voices_d[alloc_idx].rank   = '0;
          end else begin
            voices_d[alloc_idx].active = 1'b0;
          end
        end
        state_d = StIdle;
      end

      StSweep: begin
        out_valid_d  = 1'b1;
        out_voice_d  = cnt_q;
        out_gate_d   = voices_q[cnt_q].active;
        out_addr_d   = voices_q[cnt_q].phase[PHASE_W-1 -: ADDR_W];
        out_interp_d = voices_q[cnt_q].phase[FRAC_W-1:0];
        if (voices_q[cnt_q].active) begin
          voices_d[cnt_q].phase = voices_q[cnt_q].phase + voices_q[cnt_q].inc;
        end
        if (cnt_q == VOICE_W'(NUM_VOICES - 1)) begin
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase

    if (sampleTick && (state_q != StIdle)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= StIdle;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        voices_q[v] <= voice_reset(v);
      end
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      evt_on_q     <= 1'b0;
      evt_note_q   <= '0;
      evt_inc_q    <= '0;
      out_valid_q  <= 1'b0;
      out_voice_q  <= '0;
      out_gate_q   <= 1'b0;
      out_addr_q   <= '0;
      out_interp_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      voices_q     <= voices_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      evt_on_q     <= evt_on_d;
      evt_note_q   <= evt_note_d;
      evt_inc_q    <= evt_inc_d;
      out_valid_q  <= out_valid_d;
      out_voice_q  <= out_voice_d;
      out_gate_q   <= out_gate_d;
      out_addr_q   <= out_addr_d;
      out_interp_q <= out_interp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign outValid      = out_valid_q;
  assign outVoice      = out_voice_q;
  assign outGate       = out_gate_q;
  assign wavetableAddr = out_addr_q;
  assign interp        = out_interp_q;
  assign frameDone     = frame_done_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: a queue-based voice model predicts every sweep result.
module tb_voice_scheduler;

  localparam int N  = 8;
  localparam int VW = $clog2(N);

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          sampleTick = 1'b0;
  logic          evtValid = 1'b0;
  logic          evtNoteOn = 1'b0;
  logic [6:0]    evtNote = '0;
  logic [31:0]   evtPhaseInc = '0;
  logic          evtReady;
  logic          outValid;
  logic [VW-1:0] outVoice;
  logic          outGate;
  logic [11:0]   wavetableAddr;
  logic [19:0]   interp;
  logic          frameDone;
  logic          overrun;

  voice_scheduler #(
    .NUM_VOICES (N)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .sampleTick    (sampleTick),
    .evtValid      (evtValid),
    .evtReady      (evtReady),
    .evtNoteOn     (evtNoteOn),
    .evtNote       (evtNote),
    .evtPhaseInc   (evtPhaseInc),
    .outValid      (outValid),
    .outVoice      (outVoice),
    .outGate       (outGate),
    .wavetableAddr (wavetableAddr),
    .interp        (interp),
    .frameDone     (frameDone),
    .overrun       (overrun)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit [VW-1:0] voice;
    bit          gate;
    bit [11:0]   addr;
    bit [19:0]   frac;
    bit          done;
  } res_t;

  res_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural voice model; age list holds voice indices newest first.
  bit        m_active[N];
  bit [6:0]  m_note[N];
  bit [31:0] m_inc[N];
  bit [31:0] m_phase[N];
  int        m_age[$];

  function automatic void model_reset();
    m_age.delete();
    for (int i = 0; i < N; i++) begin
      m_active[i] = 1'b0;
      m_note[i]   = '0;
      m_inc[i]    = '0;
      m_phase[i]  = '0;
      m_age.push_back(i);
    end
  endfunction

  function automatic void model_note_on(bit [6:0] n, bit [31:0] inc);
    int v = -1;
    for (int i = 0; i < N; i++) if (v < 0 && m_active[i] && m_note[i] == n) v = i;
    for (int i = 0; i < N; i++) if (v < 0 && !m_active[i]) v = i;
    if (v < 0) v = m_age[m_age.size() - 1];
    m_active[v] = 1'b1;
    m_note[v]   = n;
    m_inc[v]    = inc;
    m_phase[v]  = '0;
    for (int i = 0; i < m_age.size(); i++) begin
      if (m_age[i] == v) begin
        m_age.delete(i);
        break;
      end
    end
    m_age.push_front(v);
  endfunction

  function automatic void model_note_off(bit [6:0] n);
    for (int i = 0; i < N; i++) begin
      if (m_active[i] && m_note[i] == n) begin
        m_active[i] = 1'b0;
        break;
      end
    end
  endfunction

  function automatic void model_sweep();
    res_t r;
    for (int v = 0; v < N; v++) begin
      r.voice = VW'(v);
      r.gate  = m_active[v];
      r.addr  = m_phase[v][31:20];
      r.frac  = m_phase[v][19:0];
      r.done  = (v == N - 1);
      exp_q.push_back(r);
      if (m_active[v]) m_phase[v] = m_phase[v] + m_inc[v];
    end
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every sweep result is popped and compared; idle cycles must be quiet.
  always @(negedge Clk) begin
    res_t e;
    if (Reset_n) begin
      if (outValid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_result: voice %0d arrived, nothing expected", outVoice);
        end else begin
          e = exp_q.pop_front();
          if (outVoice !== e.voice || outGate !== e.gate || wavetableAddr !== e.addr ||
              interp !== e.frac || frameDone !== e.done) begin
            miscompares++;
            $display("FAIL sweep_result: got v%0d g%0b a%03h f%05h d%0b, expected v%0d g%0b a%03h f%05h d%0b",
                     outVoice, outGate, wavetableAddr, interp, frameDone,
                     e.voice, e.gate, e.addr, e.frac, e.done);
          end
        end
      end else begin
        check("idle_strobes", {30'd0, frameDone, outGate}, 32'd0);
      end
    end
  end

  // All driver tasks start and end at a falling edge.
  task automatic send_event(bit on, bit [6:0] n, bit [31:0] inc);
    int waited = 0;
    evtValid    = 1'b1;
    evtNoteOn   = on;
    evtNote     = n;
    evtPhaseInc = inc;
    while (!evtReady && waited < 100) begin
      @(negedge Clk);
      waited++;
    end
    if (!evtReady) begin
      vectors++;
      miscompares++;
      $display("FAIL evt_ready_timeout: evtReady 0 after %0d cycles, expected 1", waited);
      evtValid = 1'b0;
      return;
    end
    @(posedge Clk);
    if (on) model_note_on(n, inc);
    else    model_note_off(n);
    @(negedge Clk);
    evtValid = 1'b0;
  endtask

  task automatic tick();
    sampleTick = 1'b1;
    @(posedge Clk);
    model_sweep();
    @(negedge Clk);
    sampleTick = 1'b0;
  endtask

  task automatic idle(int k);
    repeat (k) @(negedge Clk);
  endtask

  task automatic tick_and_wait();
    tick();
    idle(N + 2);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    int op;
    int waited;
    bit [6:0] n;

    model_reset();
    repeat (3) @(negedge Clk);
    check("reset_outvalid", 32'(outValid), 32'd0);
    check("reset_addr", 32'(wavetableAddr), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_evtready", 32'(evtReady), 32'd1);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Reset state sweep plus first-result latency.
    sampleTick = 1'b1;
    @(posedge Clk);
    model_sweep();
    @(negedge Clk);
    sampleTick = 1'b0;
    check("latency_before_v0", 32'(outValid), 32'd0);
    @(negedge Clk);
    check("latency_v0", {27'd0, outValid, 4'(outVoice)}, {27'd0, 1'b1, 4'd0});
    idle(N + 1);

    // Single note.
    send_event(1'b1, 7'd60, 32'h0010_0000);
    repeat (3) tick_and_wait();

    // Phase wrap.
    do_reset();
    send_event(1'b1, 7'd1, 32'h8000_0001);
    repeat (3) tick_and_wait();

    // Allocation, stealing, note-off and reuse.
    do_reset();
    for (int i = 1; i <= 9; i++) send_event(1'b1, 7'(i), 32'(i) << 20);
    tick_and_wait();
    send_event(1'b0, 7'd3, 32'd0);
    send_event(1'b1, 7'd10, 32'h00A0_0000);
    repeat (2) tick_and_wait();

    // Retrigger.
    do_reset();
    send_event(1'b1, 7'd5, 32'h0030_0000);
    repeat (2) tick_and_wait();
    send_event(1'b1, 7'd5, 32'h0005_0000);
    repeat (2) tick_and_wait();

    // Tick landing during the EVENT cycle.
    send_event(1'b1, 7'd20, 32'h0100_0000);
    check("evt_ready_in_event", 32'(evtReady), 32'd0);
    tick();
    check("evt_ready_pending", 32'(evtReady), 32'd0);
    idle(N + 2);

    // Two ticks inside one sweep: one pends, the other is lost.
    tick();
    tick();
    sampleTick = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    sampleTick = 1'b0;
    check("overrun_set", 32'(overrun), 32'd1);
    idle(2 * N + 4);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of a sweep.
    tick();
    idle(2);
    Reset_n = 1'b0;
    #1;
    check("midreset_valid", 32'(outValid), 32'd0);
    check("midreset_gate", 32'(outGate), 32'd0);
    check("midreset_done", 32'(frameDone), 32'd0);
    check("midreset_addr", 32'(wavetableAddr), 32'd0);
    check("midreset_interp", 32'(interp), 32'd0);
    check("midreset_overrun", 32'(overrun), 32'd0);
    check("midreset_evtready", 32'(evtReady), 32'd1);
    exp_q.delete();
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    tick_and_wait();

    // Randomised mix of note-ons, note-offs and ticks.
    for (int k = 0; k < 300; k++) begin
      op = $urandom_range(0, 9);
      n  = 7'($urandom_range(0, 11));
      if (op <= 5)      send_event(1'b1, n, $urandom);
      else if (op <= 7) send_event(1'b0, n, 32'd0);
      else              tick_and_wait();
    end
    tick_and_wait();
    check("random_no_overrun", 32'(overrun), 32'd0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge Clk);
      waited++;
    end
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
